// File: rtl/clock_pkg.sv
// Shared types and helpers for the multi-channel alarm clock: BCD HH:MM
// record, per-channel alarm state, and time-of-day limits.
package clock_pkg;

  localparam int unsigned MAX_HOUR = 23;
  localparam int unsigned MAX_MIN  = 59;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h2;
    logic [3:0] m1;
    logic [3:0] m2;
  } bcd_hm_t;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZED
  } al_state_t;

  function automatic logic hm_valid(bcd_hm_t t);
    return (t.h2 <= 4'd9) && (t.m2 <= 4'd9) &&
           ((32'(t.h1) * 10 + 32'(t.h2)) <= MAX_HOUR) &&
           ((32'(t.m1) * 10 + 32'(t.m2)) <= MAX_MIN);
  endfunction

  // HH:MM plus n minutes, wrapping at 24 h.
  function automatic bcd_hm_t hm_add_min(bcd_hm_t t, int unsigned n);
    int unsigned tot;
    int unsigned h;
    int unsigned m;
    bcd_hm_t     r;
    tot = (32'(t.h1) * 10 + 32'(t.h2)) * (MAX_MIN + 1) + 32'(t.m1) * 10 + 32'(t.m2);
    tot = (tot + n) % ((MAX_HOUR + 1) * (MAX_MIN + 1));
    h = tot / (MAX_MIN + 1);
    m = tot % (MAX_MIN + 1);
    r.h1 = 2'(h / 10);
    r.h2 = 4'(h % 10);
    r.m1 = 4'(m / 10);
    r.m2 = 4'(m % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Time-of-day counter: prescaler plus BCD HH:MM:SS with validated load.
// Exposes the would-be next time so alarm compares can fire on the same tick.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  bcd_hm_t    ld_hm,
  output bcd_hm_t    hm,
  output logic [3:0] s1,
  output logic [3:0] s2,
  output logic       adv,
  output bcd_hm_t    nxt_hm,
  output logic [7:0] nxt_s
);

  localparam int unsigned PW = $clog2(CLK_DIV);

  logic [PW-1:0] cnt;
  logic          tick;
  logic          ld_ok;

  assign tick  = (cnt == PW'(CLK_DIV - 1));
  assign ld_ok = ld && hm_valid(ld_hm);
  // A valid load wins over a same-cycle tick, so no advance is reported.
  assign adv   = tick && !ld_ok;

  always_comb begin
    nxt_hm = hm;
    nxt_s  = {s1, s2};
    if (s2 != 4'd9) begin
      nxt_s[3:0] = s2 + 4'd1;
    end else begin
      nxt_s[3:0] = '0;
      if (s1 != 4'(MAX_MIN / 10)) begin
        nxt_s[7:4] = s1 + 4'd1;
      end else begin
        nxt_s[7:4] = '0;
        if (hm.m2 != 4'd9) begin
          nxt_hm.m2 = hm.m2 + 4'd1;
        end else begin
          nxt_hm.m2 = '0;
          if (hm.m1 != 4'(MAX_MIN / 10)) begin
            nxt_hm.m1 = hm.m1 + 4'd1;
          end else begin
            nxt_hm.m1 = '0;
            if (hm.h1 == 2'(MAX_HOUR / 10) && hm.h2 == 4'(MAX_HOUR % 10)) begin
              nxt_hm.h1 = '0;
              nxt_hm.h2 = '0;
            end else if (hm.h2 == 4'd9) begin
              nxt_hm.h1 = hm.h1 + 2'd1;
              nxt_hm.h2 = '0;
            end else begin
              nxt_hm.h2 = hm.h2 + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      hm  <= '0;
      s1  <= '0;
      s2  <= '0;
    end else if (ld_ok) begin
      cnt <= '0;
      hm  <= ld_hm;
      s1  <= '0;
      s2  <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        hm       <= nxt_hm;
        {s1, s2} <= nxt_s;
      end
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// Multi-channel alarm clock top: BCD time counter plus NUM_AL alarm channels.
// Optional snooze support is enabled by defining MULTI_ALARM_SNOOZE_EN.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter  int unsigned CLK_DIV    = 10,
  parameter  int unsigned NUM_AL     = 4,
  parameter  int unsigned SNOOZE_MIN = 5,
  localparam int unsigned SELW       = (NUM_AL > 1) ? $clog2(NUM_AL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        H_in1,
  input  logic [3:0]        H_in2,
  input  logic [3:0]        M_in1,
  input  logic [3:0]        M_in2,
  input  logic              LD_time,
  input  logic              LD_alarm,
  input  logic [SELW-1:0]   al_sel,
  input  logic [NUM_AL-1:0] AL_EN,
  input  logic              STOP_AL,
  input  logic              snooze,
  output logic [1:0]        H_out1,
  output logic [3:0]        H_out2,
  output logic [3:0]        M_out1,
  output logic [3:0]        M_out2,
  output logic [3:0]        S_out1,
  output logic [3:0]        S_out2,
  output logic [NUM_AL-1:0] ringing,
  output logic              indicator
);

  bcd_hm_t    ld_hm;
  bcd_hm_t    cur_hm;
  bcd_hm_t    nxt_hm;
  logic [7:0] nxt_s;
  logic       adv;
  logic       ld_alarm_ok;
  logic       at_sec0;

  assign ld_hm       = '{h1: H_in1, h2: H_in2, m1: M_in1, m2: M_in2};
  assign ld_alarm_ok = LD_alarm && hm_valid(ld_hm);

  bcd_time_counter #(
    .CLK_DIV(CLK_DIV)
  ) u_time (
    .clk   (clk),
    .reset (reset),
    .ld    (LD_time),
    .ld_hm (ld_hm),
    .hm    (cur_hm),
    .s1    (S_out1),
    .s2    (S_out2),
    .adv   (adv),
    .nxt_hm(nxt_hm),
    .nxt_s (nxt_s)
  );

  assign H_out1 = cur_hm.h1;
  assign H_out2 = cur_hm.h2;
  assign M_out1 = cur_hm.m1;
  assign M_out2 = cur_hm.m2;

  // Triggers compare against the time the current tick is about to produce.
  assign at_sec0 = (nxt_s == 8'h00);

  for (genvar i = 0; i < NUM_AL; i++) begin : g_ch
    bcd_hm_t   alarm;
    al_state_t st;
    al_state_t st_nxt;
    logic      hit_alarm;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        alarm <= '0;
      end else if (ld_alarm_ok && al_sel == SELW'(i)) begin
        alarm <= ld_hm;
      end
    end

    assign hit_alarm = adv && at_sec0 && (nxt_hm == alarm);

`ifdef MULTI_ALARM_SNOOZE_EN
    bcd_hm_t wake;
    logic    hit_wake;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wake <= '0;
      end else if (st == RINGING && st_nxt == SNOOZED) begin
        wake <= hm_add_min(cur_hm, SNOOZE_MIN);
      end
    end

    assign hit_wake = adv && at_sec0 && (nxt_hm == wake);
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st <= IDLE;
      end else begin
        st <= st_nxt;
      end
    end

    always_comb begin
      st_nxt = st;
      if (STOP_AL || !AL_EN[i]) begin
        st_nxt = IDLE;
      end else begin
        case (st)
          IDLE:    if (hit_alarm) st_nxt = RINGING;
`ifdef MULTI_ALARM_SNOOZE_EN
          RINGING: if (snooze) st_nxt = SNOOZED;
          SNOOZED: if (hit_wake) st_nxt = RINGING;
`else
          RINGING: st_nxt = RINGING;
`endif
          default: st_nxt = IDLE;
        endcase
      end
    end

    assign ringing[i] = (st == RINGING);
  end

`ifndef MULTI_ALARM_SNOOZE_EN
  logic unused_snooze;
  assign unused_snooze = snooze & (SNOOZE_MIN != 0);
`endif

  assign indicator = |ringing;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Self-checking bench for multi_alarm_clock: table-driven time vectors plus
// hand sequences for alarms, stop, enable, snooze and asynchronous reset.
module tb_multi_alarm_clock;

  localparam int unsigned CLK_DIV    = 10;
  localparam int unsigned NUM_AL     = 4;
  localparam int unsigned SNOOZE_MIN = 5;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in2, M_in1, M_in2;
  logic       LD_time, LD_alarm;
  logic [1:0] al_sel;
  logic [3:0] AL_EN;
  logic       STOP_AL, snooze;
  logic [1:0] H_out1;
  logic [3:0] H_out2, M_out1, M_out2, S_out1, S_out2;
  logic [3:0] ringing;
  logic       indicator;

  multi_alarm_clock #(
    .CLK_DIV   (CLK_DIV),
    .NUM_AL    (NUM_AL),
    .SNOOZE_MIN(SNOOZE_MIN)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .H_in1    (H_in1),
    .H_in2    (H_in2),
    .M_in1    (M_in1),
    .M_in2    (M_in2),
    .LD_time  (LD_time),
    .LD_alarm (LD_alarm),
    .al_sel   (al_sel),
    .AL_EN    (AL_EN),
    .STOP_AL  (STOP_AL),
    .snooze   (snooze),
    .H_out1   (H_out1),
    .H_out2   (H_out2),
    .M_out1   (M_out1),
    .M_out2   (M_out2),
    .S_out1   (S_out1),
    .S_out2   (S_out2),
    .ringing  (ringing),
    .indicator(indicator)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [21:0] t;
    logic [3:0]  r;
  } exp_t;

  typedef struct {
    int lh, lm, ticks, eh, em, es;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   tests_run    = 0;
  int   tests_failed = 0;

  function automatic logic [21:0] bcd_time(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check_sb();
    exp_t        e;
    logic [21:0] act;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {H_out1, H_out2, M_out1, M_out2, S_out1, S_out2};
      tests_run++;
      if (act !== e.t || ringing !== e.r || indicator !== (|e.r)) begin
        tests_failed++;
        $display("FAIL %s: got time=%h ring=%b ind=%b, expected time=%h ring=%b ind=%b",
                 e.name, {2'b00, act}, ringing, indicator, {2'b00, e.t}, e.r, |e.r);
      end
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push the expectation, advance n clock edges, then compare.
  task automatic run_expect(string nm, int n, int h, int m, int s, logic [3:0] r);
    sb.push_back('{name: nm, t: bcd_time(h, m, s), r: r});
    edges(n);
    check_sb();
  endtask

  task automatic set_raw(logic [1:0] h1, logic [3:0] h2, logic [3:0] m1, logic [3:0] m2);
    H_in1 = h1;
    H_in2 = h2;
    M_in1 = m1;
    M_in2 = m2;
  endtask

  task automatic set_hm(int h, int m);
    set_raw(2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10));
  endtask

  task automatic pulse_ld_time();
    LD_time = 1'b1;
    edges(1);
    LD_time = 1'b0;
  endtask

  task automatic load_time(int h, int m);
    set_hm(h, m);
    pulse_ld_time();
  endtask

  task automatic pulse_ld_alarm(int ch);
    al_sel   = 2'(ch);
    LD_alarm = 1'b1;
    edges(1);
    LD_alarm = 1'b0;
  endtask

  task automatic load_alarm(int ch, int h, int m);
    set_hm(h, m);
    pulse_ld_alarm(ch);
  endtask

  task automatic pulse_stop();
    STOP_AL = 1'b1;
    edges(1);
    STOP_AL = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] snz_r;

    vecs[0] = '{10, 30, 60, 10, 31, 0};
    vecs[1] = '{23, 59, 60, 0, 0, 0};
    vecs[2] = '{23, 59, 59, 23, 59, 59};
    vecs[3] = '{9, 59, 60, 10, 0, 0};
    vecs[4] = '{12, 34, 7, 12, 34, 7};
    vecs[5] = '{0, 0, 0, 0, 0, 0};
    vecs[6] = '{19, 59, 61, 20, 0, 1};
    vecs[7] = '{13, 58, 120, 14, 0, 0};

    reset    = 1'b0;
    set_hm(0, 0);
    LD_time  = 1'b0;
    LD_alarm = 1'b0;
    al_sel   = '0;
    AL_EN    = '0;
    STOP_AL  = 1'b0;
    snooze   = 1'b0;

    #2 reset = 1'b1;
    #2;
    run_expect("reset_state", 0, 0, 0, 0, 4'b0000);
    @(posedge clk);
    #1 reset = 1'b0;
    run_expect("first_tick_pending", 9, 0, 0, 0, 4'b0000);
    run_expect("first_tick", 1, 0, 0, 1, 4'b0000);

    for (int i = 0; i < $size(vecs); i++) begin
      load_time(vecs[i].lh, vecs[i].lm);
      run_expect($sformatf("vec%0d_%0d:%0d+%0d", i, vecs[i].lh, vecs[i].lm, vecs[i].ticks),
                 vecs[i].ticks * CLK_DIV, vecs[i].eh, vecs[i].em, vecs[i].es, 4'b0000);
    end

    // Load mid-prescaler restarts the second.
    load_time(7, 0);
    edges(5);
    load_time(8, 0);
    run_expect("presc_clear_before", 599, 8, 0, 59, 4'b0000);
    run_expect("presc_clear_at", 1, 8, 1, 0, 4'b0000);

    // Load on the tick cycle takes priority.
    load_time(6, 30);
    edges(9);
    load_time(6, 0);
    run_expect("ld_over_tick", 0, 6, 0, 0, 4'b0000);
    run_expect("ld_over_tick_hold", 9, 6, 0, 0, 4'b0000);
    run_expect("ld_over_tick_next", 1, 6, 0, 1, 4'b0000);

    // Invalid time loads are ignored and do not clear the prescaler.
    load_time(10, 0);
    edges(10);
    set_hm(24, 0);
    pulse_ld_time();
    set_raw(2'd1, 4'd2, 4'd6, 4'd0);
    pulse_ld_time();
    set_raw(2'd0, 4'd9, 4'd5, 4'd10);
    pulse_ld_time();
    set_raw(2'd0, 4'd12, 4'd0, 4'd0);
    pulse_ld_time();
    run_expect("bad_ld_ignored", 5, 10, 0, 1, 4'b0000);
    run_expect("bad_ld_keeps_presc", 1, 10, 0, 2, 4'b0000);

    // Two enabled channels trigger together; ch3 matches but is disabled.
    load_alarm(0, 10, 31);
    load_alarm(1, 10, 32);
    load_alarm(2, 10, 31);
    load_alarm(3, 10, 31);
    AL_EN = 4'b0101;
    load_time(10, 30);
    run_expect("alarm_before_tick", 599, 10, 30, 59, 4'b0000);
    run_expect("alarm_multi_ring", 1, 10, 31, 0, 4'b0101);
    pulse_stop();
    run_expect("stop_all", 0, 10, 31, 0, 4'b0000);

    // STOP_AL on the trigger edge wins.
    AL_EN = 4'b0010;
    load_time(10, 31);
    edges(599);
    STOP_AL = 1'b1;
    edges(1);
    STOP_AL = 1'b0;
    run_expect("stop_over_trigger", 0, 10, 32, 0, 4'b0000);

    // Dropping the enable silences the channel; re-enabling does not re-ring.
    load_time(10, 31);
    run_expect("ch1_ring", 600, 10, 32, 0, 4'b0010);
    AL_EN = 4'b0000;
    run_expect("en_off_idle", 1, 10, 32, 0, 4'b0000);
    AL_EN = 4'b0010;
    run_expect("en_back_no_ring", 1, 10, 32, 0, 4'b0000);

    // Invalid alarm loads leave the register unchanged; LD_time never triggers.
    load_alarm(0, 10, 40);
    load_alarm(0, 24, 0);
    set_raw(2'd1, 4'd2, 4'd6, 4'd0);
    pulse_ld_alarm(0);
    AL_EN = 4'b0001;
    load_time(10, 40);
    run_expect("ld_time_no_trigger", 0, 10, 40, 0, 4'b0000);
    run_expect("ld_time_no_trigger_late", 1, 10, 40, 0, 4'b0000);
    load_time(10, 39);
    run_expect("alarm_kept_10_40", 600, 10, 40, 0, 4'b0001);
    pulse_stop();
    run_expect("stop_ch0", 0, 10, 40, 0, 4'b0000);

    // Snooze: ch1 at 07:00, snooze at 07:00:20, wake at 07:05:00.
`ifdef MULTI_ALARM_SNOOZE_EN
    snz_r = 4'b0000;
`else
    snz_r = 4'b0010;
`endif
    load_alarm(1, 7, 0);
    AL_EN = 4'b0010;
    load_time(6, 59);
    run_expect("snz_ring", 600, 7, 0, 0, 4'b0010);
    run_expect("snz_still_ring", 200, 7, 0, 20, 4'b0010);
    snooze = 1'b1;
    edges(1);
    snooze = 1'b0;
    run_expect("snz_pulse", 0, 7, 0, 20, snz_r);
    run_expect("snz_before_wake", 2798, 7, 4, 59, snz_r);
    run_expect("snz_wake", 1, 7, 5, 0, 4'b0010);

    // Asynchronous reset while ringing, away from any clock edge.
    #2 reset = 1'b1;
    #1;
    run_expect("async_reset", 0, 0, 0, 0, 4'b0000);
    edges(2);
    run_expect("reset_held", 0, 0, 0, 0, 4'b0000);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
